// File: rtl/ifetch_pc_sched_pkg.sv
// Shared types and helpers for the instruction-fetch PC scheduler.
// Thread-indexed types are sized for the largest supported core (16 threads,
// 4-instruction fetch blocks); per-instance widths are derived from parameters.
package ifetch_pc_sched_pkg;

    localparam int MAX_THREADS     = 16;
    localparam int MAX_FETCH_INSTS = 4;

    typedef logic [$clog2(MAX_THREADS)-1:0] local_thread_idx_t;
    typedef logic [MAX_THREADS-1:0]         local_thread_bitmap_t;

    // One fetch as handed from the tag stage to the data stage.
    typedef struct packed {
        logic [31:0]                pc;
        local_thread_idx_t          thread_idx;
        logic [MAX_FETCH_INSTS-1:0] lane_mask;
    } fetch_block_t;

    // Byte-offset width of a fetch block holding fetch_insts 32-bit words.
    function automatic int fetch_offset_bits(input int fetch_insts);
        return $clog2(4 * fetch_insts);
    endfunction

    // One-hot to binary index; an all-zero input yields index 0.
    function automatic local_thread_idx_t oh_to_idx(input local_thread_bitmap_t oh);
        local_thread_idx_t idx;
        idx = '0;
        for (int i = 0; i < MAX_THREADS; i++) begin
            if (oh[i]) begin
                idx = idx | local_thread_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ifetch_pc_sched_arbiter.sv
// Thread arbiter for the fetch scheduler: round-robin or fixed priority,
// one-hot grant. Optional starvation guard enabled by IFETCH_STARVATION_GUARD_EN.
module ifetch_thread_arbiter
    import ifetch_pc_sched_pkg::*;
#(
    parameter int NUM_THREADS  = 4,
    parameter int STARVE_LIMIT = 15,
    localparam int TIDX_W      = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_THREADS-1:0] eligible_i,
    input  logic                   fixed_prio_i,
    input  logic                   advance_i,
    output logic [NUM_THREADS-1:0] grant_o
);

    logic [TIDX_W-1:0]      ptr_q, ptr_d;
    logic [NUM_THREADS-1:0] rr_grant, fx_grant, base_grant;
    logic                   rr_found;
    int                     rr_idx;

    // Round-robin search starting at the pointer (the thread after the last grant).
    always_comb begin
        rr_grant = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            rr_idx = (int'(ptr_q) + k) % NUM_THREADS;
            if (!rr_found && eligible_i[TIDX_W'(rr_idx)]) begin
                rr_grant[TIDX_W'(rr_idx)] = 1'b1;
                rr_found = 1'b1;
            end
        end
    end

    assign fx_grant   = eligible_i & (~eligible_i + NUM_THREADS'(1));
    assign base_grant = fixed_prio_i ? fx_grant : rr_grant;

`ifdef IFETCH_STARVATION_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [NUM_THREADS-1:0] starved;
    logic [NUM_THREADS-1:0] starve_grant;

    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_q;
            assign starved[gi] = eligible_i[gi] && (cnt_q >= CNT_W'(STARVE_LIMIT));
            // Count eligible-but-ungranted cycles, saturating at the limit.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                end else if (!eligible_i[gi] || (grant_o[gi] && advance_i)) begin
                    cnt_q <= '0;
                end else if (!starved[gi]) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    endgenerate

    // A starved thread overrides both modes; lowest starved index first.
    assign starve_grant = starved & (~starved + NUM_THREADS'(1));
    assign grant_o      = (|starved) ? starve_grant : base_grant;
`else
    assign grant_o = base_grant;
`endif

    // Pointer moves past the granted thread only when a fetch actually issues.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && (|grant_o)) begin
            ptr_d = TIDX_W'((int'(oh_to_idx(local_thread_bitmap_t'(grant_o))) + 1) % NUM_THREADS);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ifetch_pc_sched.sv
// Instruction-fetch tag-stage thread scheduler and PC generator.
// Picks one eligible thread per cycle, drives its block-aligned address to the
// tag SRAM/TLB/LRU and registers PC, thread and lane mask for the data stage.
// Optional starvation guard: define IFETCH_STARVATION_GUARD_EN.
module ifetch_pc_sched
    import ifetch_pc_sched_pkg::*;
#(
    parameter int          NUM_THREADS  = 4,
    parameter int          FETCH_INSTS  = 1,
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int          STARVE_LIMIT = 15,
    localparam int         TIDX_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
)(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_THREADS-1:0] ts_fetch_en,
    input  logic                   fetch_block,
    input  logic                   arb_fixed_prio,
    input  logic                   ocd_halt,
    input  logic [TIDX_W-1:0]      ocd_thread,
    input  logic                   ifd_cache_miss,
    input  logic                   ifd_near_miss,
    input  logic [TIDX_W-1:0]      ifd_miss_thread_idx,
    input  logic [31:0]            ifd_miss_pc,
    input  logic [NUM_THREADS-1:0] l2i_wake_bitmap,
    input  logic                   wb_rollback_en,
    input  logic [TIDX_W-1:0]      wb_rollback_thread_idx,
    input  logic [31:0]            wb_rollback_pc,
    output logic                   fetch_en,
    output logic [31:0]            fetch_addr,
    output logic [TIDX_W-1:0]      fetch_thread_idx,
    output logic                   ift_instruction_requested,
    output logic [31:0]            ift_pc_vaddr,
    output logic [TIDX_W-1:0]      ift_thread_idx,
    output logic [FETCH_INSTS-1:0] ift_lane_mask,
    output logic [NUM_THREADS-1:0] wait_threads
);

    localparam int          FETCH_OFFSET_BITS = fetch_offset_bits(FETCH_INSTS);
    localparam logic [31:0] BLK_BYTES         = 32'(4 * FETCH_INSTS);
    localparam logic [31:0] ALIGN_MASK        = ~(BLK_BYTES - 32'd1);

    logic [31:0]            pc_q [NUM_THREADS];
    logic [31:0]            pc_d [NUM_THREADS];
    logic [NUM_THREADS-1:0] wait_q, wait_d;
    logic [NUM_THREADS-1:0] eligible, grant_oh, rb_hit, ms_hit;
    logic [TIDX_W-1:0]      grant_idx, sel_idx;
    logic [31:0]            sel_pc;
    logic [FETCH_INSTS-1:0] lane_mask;
    logic                   req_q, req_d, ift_hit;
    logic [31:0]            ift_pc_q;
    logic [TIDX_W-1:0]      ift_tid_q;
    logic [FETCH_INSTS-1:0] ift_mask_q;

    assign eligible = ts_fetch_en & ~wait_q;
    assign fetch_en = (|eligible) & ~fetch_block & ~ocd_halt;

    ifetch_thread_arbiter #(
        .NUM_THREADS  (NUM_THREADS),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk          (clk),
        .reset_n      (reset_n),
        .eligible_i   (eligible),
        .fixed_prio_i (arb_fixed_prio),
        .advance_i    (fetch_en),
        .grant_o      (grant_oh)
    );

    assign grant_idx        = TIDX_W'(oh_to_idx(local_thread_bitmap_t'(grant_oh)));
    assign sel_idx          = ocd_halt ? ocd_thread : grant_idx;
    assign fetch_thread_idx = sel_idx;
    assign fetch_addr       = sel_pc & ALIGN_MASK;

    // PC of the thread steering the address mux (debugger thread when halted).
    always_comb begin
        sel_pc = pc_q[0];
        for (int t = 1; t < NUM_THREADS; t++) begin
            if (sel_idx == TIDX_W'(t)) begin
                sel_pc = pc_q[t];
            end
        end
    end

    // Lanes at or above the word offset of the PC inside its block are valid.
    generate
        if (FETCH_INSTS == 1) begin : g_single_lane
            assign lane_mask = 1'b1;
        end else begin : g_multi_lane
            logic [FETCH_OFFSET_BITS-3:0] word_off;
            assign word_off = sel_pc[FETCH_OFFSET_BITS-1:2];
            for (genvar gi = 0; gi < FETCH_INSTS; gi++) begin : g_lane
                assign lane_mask[gi] = (word_off <= (FETCH_OFFSET_BITS-2)'(gi));
            end
        end
    endgenerate

    // Per-thread redirect hits and sleep tracking; wake beats a same-cycle sleep.
    generate
        for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thr
            assign rb_hit[gi] = wb_rollback_en && (wb_rollback_thread_idx == TIDX_W'(gi));
            assign ms_hit[gi] = (ifd_cache_miss || ifd_near_miss)
                                && (ifd_miss_thread_idx == TIDX_W'(gi));
            assign wait_d[gi] = (wait_q[gi] | (ifd_cache_miss
                                && (ifd_miss_thread_idx == TIDX_W'(gi))))
                                & ~l2i_wake_bitmap[gi];
        end
    endgenerate

    // Next PC per thread: rollback, then miss replay, then sequential advance.
    always_comb begin
        for (int t = 0; t < NUM_THREADS; t++) begin
            pc_d[t] = pc_q[t];
            if (rb_hit[t]) begin
                pc_d[t] = wb_rollback_pc;
            end else if (ms_hit[t]) begin
                pc_d[t] = ifd_miss_pc;
            end else if (fetch_en && grant_oh[t]) begin
                pc_d[t] = (pc_q[t] & ALIGN_MASK) + BLK_BYTES;
            end
        end
    end

    // A fetch whose own thread is redirected this cycle is never requested.
    assign req_d   = fetch_en & ~(|((rb_hit | ms_hit) & grant_oh));

    // Redirect of the thread already in the output register squashes that fetch.
    assign ift_hit = (wb_rollback_en && (wb_rollback_thread_idx == ift_tid_q))
                     || ((ifd_cache_miss || ifd_near_miss) && (ifd_miss_thread_idx == ift_tid_q));

    // Per-thread PC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= RESET_PC;
            end
        end else begin
            for (int t = 0; t < NUM_THREADS; t++) begin
                pc_q[t] <= pc_d[t];
            end
        end
    end

    // Tag-stage output register and sleep bitmap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= 1'b0;
            ift_pc_q   <= 32'h0;
            ift_tid_q  <= '0;
            ift_mask_q <= '0;
            wait_q     <= '0;
        end else begin
            req_q      <= req_d;
            ift_pc_q   <= sel_pc;
            ift_tid_q  <= sel_idx;
            ift_mask_q <= lane_mask;
            wait_q     <= wait_d;
        end
    end

    assign ift_instruction_requested = req_q & ~ift_hit;
    assign ift_pc_vaddr              = ift_pc_q;
    assign ift_thread_idx            = ift_tid_q;
    assign ift_lane_mask             = ift_mask_q;
    assign wait_threads              = wait_q;

endmodule
